// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared constants, state and owner-tag encodings for the instruction SRAM arbiter
package imem_pkg;

    localparam int IMEM_DEPTH = 816;
    localparam int IMEM_AW    = 10;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_F    = 2'd1,
        OWN_L    = 2'd2
    } owner_t;

endpackage

// File: rtl/imem_port_arbiter_if.sv
// rtl/imem_port_arbiter_if.sv - fetch, loader and status signals between requesters and the imem arbiter
interface imem_port_arbiter_if
    import imem_pkg::*;
#(
    parameter int AW = IMEM_AW
);

    logic          f_req_i;
    logic [AW-1:0] f_addr_i;
    logic          f_gnt_o;
    logic          f_stall_o;
    logic          f_rvalid_o;
    logic          l_req_i;
    logic          l_we_i;
    logic [AW-1:0] l_addr_i;
    logic [31:0]   l_wdata_i;
    logic          l_gnt_o;
    logic          l_rvalid_o;
    logic [31:0]   rdata_o;
    logic          boot_done_i;
    logic          running_o;
    logic          addr_err_o;

    modport slave (
        input  f_req_i, f_addr_i, l_req_i, l_we_i, l_addr_i, l_wdata_i, boot_done_i,
        output f_gnt_o, f_stall_o, f_rvalid_o, l_gnt_o, l_rvalid_o, rdata_o,
               running_o, addr_err_o
    );

    modport master (
        output f_req_i, f_addr_i, l_req_i, l_we_i, l_addr_i, l_wdata_i, boot_done_i,
        input  f_gnt_o, f_stall_o, f_rvalid_o, l_gnt_o, l_rvalid_o, rdata_o,
               running_o, addr_err_o
    );

endinterface

// File: rtl/sram_1p_32x816.sv
// rtl/sram_1p_32x816.sv - single-port 32-bit SRAM model, active-low CEB/WEB, 1-cycle read latency
module sram_1p_32x816
    import imem_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = IMEM_AW
) (
    input  logic          clk,
    input  logic          ceb,
    input  logic          web,
    input  logic [AW-1:0] a,
    input  logic [31:0]   d,
    output logic [31:0]   q
);

    logic [31:0] mem [DEPTH];

    // Q holds its last value on cycles without a read, like the hard macro.
    always_ff @(posedge clk) begin
        if (!ceb) begin
            if (!web) begin
                mem[a] <= d;
            end else begin
                q <= mem[a];
            end
        end
    end

endmodule

// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - boot-sequenced fetch/loader arbiter for the instruction SRAM; IMEM_ARB_STARVE_GUARD_EN adds the fetch starvation guard
module imem_port_arbiter
    import imem_pkg::*;
#(
    parameter int DEPTH       = IMEM_DEPTH,
    parameter int AW          = IMEM_AW,
    parameter int STARVE_MAX  = 4,
    parameter int BOOT_BYPASS = 0
) (
    input  logic               clk,
    input  logic               resetn,
    imem_port_arbiter_if.slave bus
);

    localparam int unsigned DEPTH_U = DEPTH;

    state_t        state_q, state_d;
    owner_t        own_q, own_d;
    logic          oor_q, oor_d;
    logic          f_gnt, l_gnt;
    logic          fetch_wins;
    logic          f_oor, l_oor;
    logic          ceb, web;
    logic [AW-1:0] sram_a;
    logic [31:0]   sram_q;

    assign f_oor = (32'(bus.f_addr_i) >= DEPTH_U);
    assign l_oor = (32'(bus.l_addr_i) >= DEPTH_U);

`ifdef IMEM_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_q, starve_d;

    assign fetch_wins = (starve_q == SW'(STARVE_MAX));

    always_comb begin
        starve_d = starve_q;
        if (state_q == ST_RUN) begin
            if (!bus.f_req_i || f_gnt) begin
                starve_d = '0;
            end else if (starve_q != SW'(STARVE_MAX)) begin
                starve_d = starve_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    logic starve_unused;
    assign starve_unused = |STARVE_MAX;
    assign fetch_wins    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= (BOOT_BYPASS != 0) ? ST_RUN : ST_BOOT;
            own_q   <= OWN_NONE;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            oor_q   <= oor_d;
        end
    end

    always_comb begin
        state_d = state_q;
        f_gnt   = 1'b0;
        l_gnt   = 1'b0;
        own_d   = OWN_NONE;
        oor_d   = 1'b0;
        ceb     = 1'b1;
        web     = 1'b1;
        sram_a  = '0;

        if (state_q == ST_BOOT) begin
            l_gnt = bus.l_req_i;
            if (bus.boot_done_i) begin
                state_d = ST_RUN;
            end
        end else if (bus.f_req_i && (!bus.l_req_i || fetch_wins)) begin
            f_gnt = 1'b1;
        end else begin
            l_gnt = bus.l_req_i;
        end

        // Out-of-range accesses are granted but never reach the array.
        if (f_gnt) begin
            sram_a = bus.f_addr_i;
            ceb    = f_oor;
            own_d  = OWN_F;
            oor_d  = f_oor;
        end else if (l_gnt) begin
            sram_a = bus.l_addr_i;
            ceb    = l_oor;
            web    = ~bus.l_we_i;
            own_d  = bus.l_we_i ? OWN_NONE : OWN_L;
            oor_d  = l_oor;
        end
    end

    sram_1p_32x816 #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sram (
        .clk (clk),
        .ceb (ceb),
        .web (web),
        .a   (sram_a),
        .d   (bus.l_wdata_i),
        .q   (sram_q)
    );

    assign bus.f_gnt_o    = f_gnt;
    assign bus.l_gnt_o    = l_gnt;
    assign bus.f_stall_o  = bus.f_req_i & ~f_gnt;
    assign bus.f_rvalid_o = (own_q == OWN_F);
    assign bus.l_rvalid_o = (own_q == OWN_L);
    assign bus.rdata_o    = ((own_q != OWN_NONE) && !oor_q) ? sram_q : 32'd0;
    assign bus.running_o  = (state_q == ST_RUN);
    assign bus.addr_err_o = oor_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb/tb_imem_port_arbiter.sv - directed self-checking bench for imem_port_arbiter
module tb_imem_port_arbiter;

    logic clk;
    logic resetn;
    int   checks;
    int   fails;

    imem_port_arbiter_if #(.AW(10)) bus ();

    imem_port_arbiter #(
        .DEPTH       (816),
        .AW          (10),
        .STARVE_MAX  (4),
        .BOOT_BYPASS (0)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.f_req_i     = 1'b0;
        bus.f_addr_i    = '0;
        bus.l_req_i     = 1'b0;
        bus.l_we_i      = 1'b0;
        bus.l_addr_i    = '0;
        bus.l_wdata_i   = '0;
        bus.boot_done_i = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        resetn = 1'b0;
        step();
        step();
        checks++; if (bus.running_o !== 1'b0) begin fails++; $display("FAIL reset_running got %b exp 0", bus.running_o); end
        checks++; if (bus.f_rvalid_o !== 1'b0) begin fails++; $display("FAIL reset_f_rvalid got %b exp 0", bus.f_rvalid_o); end
        checks++; if (bus.l_rvalid_o !== 1'b0) begin fails++; $display("FAIL reset_l_rvalid got %b exp 0", bus.l_rvalid_o); end
        checks++; if (bus.addr_err_o !== 1'b0) begin fails++; $display("FAIL reset_addr_err got %b exp 0", bus.addr_err_o); end
        checks++; if (bus.rdata_o !== 32'd0) begin fails++; $display("FAIL reset_rdata got %h exp 0", bus.rdata_o); end
        resetn       = 1'b1;
        bus.f_req_i  = 1'b1;
        bus.f_addr_i = 10'd0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (bus.f_gnt_o !== 1'b0) begin fails++; $display("FAIL boot_f_gnt cyc %0d got %b exp 0", i, bus.f_gnt_o); end
            checks++; if (bus.f_stall_o !== 1'b1) begin fails++; $display("FAIL boot_f_stall cyc %0d got %b exp 1", i, bus.f_stall_o); end
            checks++; if (bus.running_o !== 1'b0) begin fails++; $display("FAIL boot_running cyc %0d got %b exp 0", i, bus.running_o); end
            step();
        end
    endtask

    task automatic test_boot_and_fetch();
        bus.l_req_i   = 1'b1;
        bus.l_we_i    = 1'b1;
        bus.l_addr_i  = 10'd5;
        bus.l_wdata_i = 32'hDEADBEEF;
        #1;
        checks++; if (bus.l_gnt_o !== 1'b1) begin fails++; $display("FAIL boot_l_gnt got %b exp 1", bus.l_gnt_o); end
        checks++; if (bus.f_gnt_o !== 1'b0) begin fails++; $display("FAIL boot_f_gnt_with_loader got %b exp 0", bus.f_gnt_o); end
        step();
        bus.l_addr_i    = 10'd6;
        bus.l_wdata_i   = 32'h12345678;
        bus.boot_done_i = 1'b1;
        #1;
        checks++; if (bus.running_o !== 1'b0) begin fails++; $display("FAIL done_cycle_running got %b exp 0", bus.running_o); end
        checks++; if (bus.l_gnt_o !== 1'b1) begin fails++; $display("FAIL done_cycle_l_gnt got %b exp 1", bus.l_gnt_o); end
        step();
        bus.l_req_i     = 1'b0;
        bus.l_we_i      = 1'b0;
        bus.boot_done_i = 1'b0;
        bus.f_addr_i    = 10'd5;
        #1;
        checks++; if (bus.running_o !== 1'b1) begin fails++; $display("FAIL run_running got %b exp 1", bus.running_o); end
        checks++; if (bus.f_gnt_o !== 1'b1) begin fails++; $display("FAIL run_f_gnt got %b exp 1", bus.f_gnt_o); end
        checks++; if (bus.f_stall_o !== 1'b0) begin fails++; $display("FAIL run_f_stall got %b exp 0", bus.f_stall_o); end
        step();
        bus.f_addr_i = 10'd6;
        #1;
        checks++; if (bus.f_rvalid_o !== 1'b1) begin fails++; $display("FAIL fetch5_rvalid got %b exp 1", bus.f_rvalid_o); end
        checks++; if (bus.l_rvalid_o !== 1'b0) begin fails++; $display("FAIL fetch5_l_rvalid got %b exp 0", bus.l_rvalid_o); end
        checks++; if (bus.rdata_o !== 32'hDEADBEEF) begin fails++; $display("FAIL fetch5_rdata got %h exp deadbeef", bus.rdata_o); end
        step();
        bus.f_req_i = 1'b0;
        #1;
        checks++; if (bus.f_rvalid_o !== 1'b1) begin fails++; $display("FAIL fetch6_rvalid got %b exp 1", bus.f_rvalid_o); end
        checks++; if (bus.rdata_o !== 32'h12345678) begin fails++; $display("FAIL fetch6_rdata got %h exp 12345678", bus.rdata_o); end
        step();
        checks++; if (bus.f_rvalid_o !== 1'b0) begin fails++; $display("FAIL fetch_idle_rvalid got %b exp 0", bus.f_rvalid_o); end
    endtask

    task automatic test_contention();
        bus.l_req_i   = 1'b1;
        bus.l_we_i    = 1'b1;
        bus.l_addr_i  = 10'd7;
        bus.l_wdata_i = 32'hA5A50007;
        step();
        bus.l_we_i   = 1'b0;
        bus.f_req_i  = 1'b1;
        bus.f_addr_i = 10'd5;
        #1;
        checks++; if (bus.l_rvalid_o !== 1'b0) begin fails++; $display("FAIL write_no_rvalid got %b exp 0", bus.l_rvalid_o); end
        checks++; if (bus.l_gnt_o !== 1'b1) begin fails++; $display("FAIL contend_l_gnt got %b exp 1", bus.l_gnt_o); end
        checks++; if (bus.f_gnt_o !== 1'b0) begin fails++; $display("FAIL contend_f_gnt got %b exp 0", bus.f_gnt_o); end
        checks++; if (bus.f_stall_o !== 1'b1) begin fails++; $display("FAIL contend_f_stall got %b exp 1", bus.f_stall_o); end
        step();
        bus.l_req_i = 1'b0;
        #1;
        checks++; if (bus.l_rvalid_o !== 1'b1) begin fails++; $display("FAIL contend_l_rvalid got %b exp 1", bus.l_rvalid_o); end
        checks++; if (bus.f_rvalid_o !== 1'b0) begin fails++; $display("FAIL contend_f_rvalid got %b exp 0", bus.f_rvalid_o); end
        checks++; if (bus.rdata_o !== 32'hA5A50007) begin fails++; $display("FAIL contend_rdata got %h exp a5a50007", bus.rdata_o); end
        checks++; if (bus.f_gnt_o !== 1'b1) begin fails++; $display("FAIL after_contend_f_gnt got %b exp 1", bus.f_gnt_o); end
        step();
        bus.f_req_i = 1'b0;
        #1;
        checks++; if (bus.f_rvalid_o !== 1'b1) begin fails++; $display("FAIL late_fetch_rvalid got %b exp 1", bus.f_rvalid_o); end
        checks++; if (bus.rdata_o !== 32'hDEADBEEF) begin fails++; $display("FAIL late_fetch_rdata got %h exp deadbeef", bus.rdata_o); end
        step();
    endtask

    task automatic test_addr_err();
        bus.l_req_i  = 1'b1;
        bus.l_we_i   = 1'b0;
        bus.l_addr_i = 10'd900;
        #1;
        checks++; if (bus.l_gnt_o !== 1'b1) begin fails++; $display("FAIL oor_read_gnt got %b exp 1", bus.l_gnt_o); end
        step();
        bus.l_req_i = 1'b0;
        #1;
        checks++; if (bus.l_rvalid_o !== 1'b1) begin fails++; $display("FAIL oor_read_rvalid got %b exp 1", bus.l_rvalid_o); end
        checks++; if (bus.rdata_o !== 32'd0) begin fails++; $display("FAIL oor_read_rdata got %h exp 0", bus.rdata_o); end
        checks++; if (bus.addr_err_o !== 1'b1) begin fails++; $display("FAIL oor_read_err got %b exp 1", bus.addr_err_o); end
        step();
        checks++; if (bus.addr_err_o !== 1'b0) begin fails++; $display("FAIL oor_err_pulse got %b exp 0", bus.addr_err_o); end
        bus.l_req_i   = 1'b1;
        bus.l_we_i    = 1'b1;
        bus.l_wdata_i = 32'hFFFFFFFF;
        #1;
        checks++; if (bus.l_gnt_o !== 1'b1) begin fails++; $display("FAIL oor_write_gnt got %b exp 1", bus.l_gnt_o); end
        step();
        bus.l_we_i   = 1'b0;
        bus.l_addr_i = 10'd7;
        #1;
        checks++; if (bus.addr_err_o !== 1'b1) begin fails++; $display("FAIL oor_write_err got %b exp 1", bus.addr_err_o); end
        checks++; if (bus.l_rvalid_o !== 1'b0) begin fails++; $display("FAIL oor_write_rvalid got %b exp 0", bus.l_rvalid_o); end
        step();
        bus.l_req_i = 1'b0;
        #1;
        checks++; if (bus.rdata_o !== 32'hA5A50007) begin fails++; $display("FAIL post_oor_rdata got %h exp a5a50007", bus.rdata_o); end
        checks++; if (bus.addr_err_o !== 1'b0) begin fails++; $display("FAIL in_range_err got %b exp 0", bus.addr_err_o); end
        step();
    endtask

    task automatic test_starve();
        logic exp_f;
        bus.f_req_i  = 1'b1;
        bus.f_addr_i = 10'd5;
        bus.l_req_i  = 1'b1;
        bus.l_we_i   = 1'b0;
        bus.l_addr_i = 10'd7;
        for (int k = 1; k <= 8; k++) begin
`ifdef IMEM_ARB_STARVE_GUARD_EN
            exp_f = (k == 5);
`else
            exp_f = 1'b0;
`endif
            #1;
            checks++; if (bus.f_gnt_o !== exp_f) begin fails++; $display("FAIL starve_f_gnt cyc %0d got %b exp %b", k, bus.f_gnt_o, exp_f); end
            checks++; if (bus.l_gnt_o !== !exp_f) begin fails++; $display("FAIL starve_l_gnt cyc %0d got %b exp %b", k, bus.l_gnt_o, !exp_f); end
            step();
        end
        idle();
        step();
    endtask

    task automatic test_reset_inflight();
        bus.f_req_i  = 1'b1;
        bus.f_addr_i = 10'd5;
        resetn       = 1'b0;
        #1;
        checks++; if (bus.f_gnt_o !== 1'b1) begin fails++; $display("FAIL pre_reset_f_gnt got %b exp 1", bus.f_gnt_o); end
        step();
        checks++; if (bus.f_rvalid_o !== 1'b0) begin fails++; $display("FAIL inflight_f_rvalid got %b exp 0", bus.f_rvalid_o); end
        checks++; if (bus.running_o !== 1'b0) begin fails++; $display("FAIL inflight_running got %b exp 0", bus.running_o); end
        checks++; if (bus.rdata_o !== 32'd0) begin fails++; $display("FAIL inflight_rdata got %h exp 0", bus.rdata_o); end
        checks++; if (bus.addr_err_o !== 1'b0) begin fails++; $display("FAIL inflight_err got %b exp 0", bus.addr_err_o); end
        checks++; if (bus.l_rvalid_o !== 1'b0) begin fails++; $display("FAIL inflight_l_rvalid got %b exp 0", bus.l_rvalid_o); end
        checks++; if (bus.f_gnt_o !== 1'b0) begin fails++; $display("FAIL reboot_f_gnt got %b exp 0", bus.f_gnt_o); end
        checks++; if (bus.f_stall_o !== 1'b1) begin fails++; $display("FAIL reboot_f_stall got %b exp 1", bus.f_stall_o); end
        resetn = 1'b1;
        step();
        checks++; if (bus.running_o !== 1'b0) begin fails++; $display("FAIL reboot_running got %b exp 0", bus.running_o); end
        checks++; if (bus.f_rvalid_o !== 1'b0) begin fails++; $display("FAIL reboot_f_rvalid got %b exp 0", bus.f_rvalid_o); end
        idle();
        step();
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        resetn = 1'b0;
        idle();
        @(negedge clk);
        test_reset();
        test_boot_and_fetch();
        test_contention();
        test_addr_err();
        test_starve();
        test_reset_inflight();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
